sync_rr_arbiter: RTL and testbench

Arbitrates a shared single-user resource, such as the AES core datapath, among NUM_REQ requesters.
- Requesters drive asynchronous request lines from other clock domains or off-chip.
- The block synchronizes each request line with a per-channel flop chain.
- It grants one requester at a time, in round-robin order, with a done/timeout release handshake.
- Sits between the external request pins or bus masters and the core's start/ownership logic.

---
 rtl/sync_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_sync_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_rr_arbiter.sv
// sync_rr_arbiter: round-robin owner of one shared resource among NUM_REQ asynchronous requesters (SYNC_BYPASS_EN drops the synchronizers).
// Latency: request to grant in SYNC_STAGES+1 edges (1 edge with SYNC_BYPASS_EN); one dead cycle follows every release.
// Backpressure: a grant is held until done, requester withdrawal, or MAX_HOLD cycles (timeout pulse), then the pointer moves on.
module sync_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] async_req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout,
  output logic [NUM_REQ-1:0] sync_req
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_t;

  logic [NUM_REQ-1:0] req_clean;

  // A non-0/1 input level is forced to 0 so nothing unknown leaks into the arbiter.
  always_comb begin
    req_clean = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (async_req[i]) req_clean[i] = 1'b1;
    end
  end

`ifdef SYNC_BYPASS_EN
  assign sync_req = req_clean;
`else
  logic [SYNC_STAGES-1:0][NUM_REQ-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_clean};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign sync_req = sync_q[SYNC_STAGES-1];
`endif

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      gidx_q, gidx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               found;
  logic               rel;
  int                 cand;
  logic [PW-1:0]      cand_idx;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    found     = 1'b0;
    rel       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    case (state_q)
      ST_IDLE: begin
        // First set request at or above the pointer, wrapping past NUM_REQ-1.
        for (int off = 0; off < NUM_REQ; off++) begin
          cand = int'(ptr_q) + off;
          if (cand >= NUM_REQ) cand = cand - NUM_REQ;
          cand_idx = PW'(cand);
          if (!found && sync_req[cand_idx]) begin
            found  = 1'b1;
            gidx_d = cand_idx;
          end
        end
        if (found) begin
          grant_d = NUM_REQ'(1) << gidx_d;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done || !sync_req[gidx_q]) begin
          rel = 1'b1;
        end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        if (rel) begin
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ptr_d   = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      gidx_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Bench for sync_rr_arbiter: directed scenarios with literal expectations, plus a
// per-cycle comparison against a sample-history model of the arbitration rules.
module tb_sync_rr_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_HOLD    = 16;

  logic       clk;
  logic       rst;
  logic       done;
  logic       busy;
  logic       timeout;
  logic [3:0] async_req;
  logic [3:0] grant;
  logic [3:0] sync_req;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  sync_rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .SYNC_STAGES(SYNC_STAGES),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .async_req(async_req),
    .done     (done),
    .grant    (grant),
    .busy     (busy),
    .timeout  (timeout),
    .sync_req (sync_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, got, exp, $time);
    end
  endtask

  // Model: every edge's request sample is logged; the synchronized view after edge j
  // is simply the sample taken SYNC_STAGES-1 edges earlier, unless a reset came since.
  typedef enum int {M_IDLE, M_GRANT, M_REL} mphase_t;
  mphase_t    m_phase = M_IDLE;
  int         m_owner = -1;
  int         m_hold  = 0;
  int         m_ptr   = 0;
  int         edge_n  = 0;
  int         last_rst_edge = 0;
  bit         m_to    = 0;
  logic [3:0] samp [4096];

  function automatic logic [3:0] m_sync_after(input int j);
    int src;
    src = j - (SYNC_STAGES - 1);
    if (src <= last_rst_edge || src < 1) return 4'b0000;
    return samp[12'(src % 4096)];
  endfunction

  initial begin : model_proc
    logic [3:0] cur;
    logic [3:0] s;
    int idx;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        m_phase = M_IDLE;
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
        m_to    = 0;
        last_rst_edge = edge_n;
      end else begin
        cur  = m_sync_after(edge_n - 1);
        m_to = 0;
        case (m_phase)
          M_IDLE: begin
            for (int off = 0; off < NUM_REQ; off++) begin
              idx = (m_ptr + off) % NUM_REQ;
              if (m_phase == M_IDLE && cur[2'(idx)]) begin
                m_owner = idx;
                m_hold  = 0;
                m_phase = M_GRANT;
              end
            end
          end
          M_GRANT: begin
            if (!done && cur[2'(m_owner)] && m_hold < MAX_HOLD - 1) begin
              m_hold++;
            end else begin
              m_to    = !done && cur[2'(m_owner)];
              m_ptr   = (m_owner + 1) % NUM_REQ;
              m_owner = -1;
              m_phase = M_REL;
            end
          end
          default: m_phase = M_IDLE;
        endcase
      end
      for (int i = 0; i < 4; i++) s[i] = (async_req[i] === 1'b1);
      samp[12'(edge_n % 4096)] = s;
    end
  end

  initial begin : compare_proc
    logic [3:0] exp_grant;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("model_grant",    32'(grant),    32'(exp_grant));
        check("model_busy",     32'(busy),     32'(m_phase == M_GRANT));
        check("model_timeout",  32'(timeout),  32'(m_to));
        check("model_sync_req", 32'(sync_req), 32'(m_sync_after(edge_n)));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; async_req = 4'b0000; done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string name, input int budget);
    int c = 0;
    while (grant == 4'b0000 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(grant != 4'b0000), 1);
  endtask

  logic [3:0] rr_log [$];
  logic [3:0] rr_exp [4];
  logic [3:0] prev;
  int         age;
  int         hold_cnt;

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rst = 1'b1; async_req = 4'b1111; done = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;

    // Reset with every request asserted
    repeat (2) begin
      @(negedge clk);
      check("rst_grant",   32'(grant),    0);
      check("rst_busy",    32'(busy),     0);
      check("rst_timeout", 32'(timeout),  0);
      check("rst_sync",    32'(sync_req), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_e1_sync",  32'(sync_req), 0);
    check("post_rst_e1_grant", 32'(grant),    0);
    @(negedge clk);
    check("post_rst_e2_sync",  32'(sync_req), 'hF);
    check("post_rst_e2_grant", 32'(grant),    0);
    @(negedge clk);
    check("post_rst_e3_grant", 32'(grant),    'h1);
    check("post_rst_e3_busy",  32'(busy),     1);

    // Single request, then release by done
    do_reset();
    @(posedge clk);
    #1 async_req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("single_sync_e1",  32'(sync_req), 0);
    @(negedge clk);
    check("single_sync_e2",  32'(sync_req), 'h4);
    check("single_grant_e2", 32'(grant),    0);
    @(negedge clk);
    check("single_grant_e3", 32'(grant),    'h4);
    check("single_busy_e3",  32'(busy),     1);
    done = 1'b1; async_req = 4'b0000;
    @(negedge clk);
    done = 1'b0;
    check("done_drop_grant",   32'(grant),   0);
    check("done_drop_busy",    32'(busy),    0);
    check("done_drop_timeout", 32'(timeout), 0);
    @(negedge clk);
    check("done_dead_grant",   32'(grant),   0);

    // Round-robin with done two cycles into each grant
    do_reset();
    async_req = 4'b1011;
    prev = 4'b0000;
    age  = 0;
    for (int c = 0; c < 200 && rr_log.size() < 4; c++) begin
      @(negedge clk);
      if (grant != 4'b0000) begin
        if (prev == 4'b0000) begin
          rr_log.push_back(grant);
          age = 0;
        end
        age++;
        done = (age == 2);
      end else begin
        done = 1'b0;
      end
      prev = grant;
    end
    done = 1'b0;
    check("rr_count", 32'(rr_log.size()), 4);
    for (int i = 0; i < rr_log.size() && i < 4; i++) check("rr_seq", 32'(rr_log[i]), 32'(rr_exp[i]));

    // Timeout with a single requester holding on
    do_reset();
    async_req = 4'b0001;
    wait_grant("to_grant", 10);
    hold_cnt = 0;
    for (int c = 0; c < 40 && grant == 4'b0001; c++) begin
      hold_cnt++;
      @(negedge clk);
    end
    check("to_hold_cycles", 32'(hold_cnt), 16);
    check("to_drop_grant",  32'(grant),    0);
    check("to_pulse",       32'(timeout),  1);
    @(negedge clk);
    check("to_pulse_end",   32'(timeout),  0);
    check("to_dead_grant",  32'(grant),    0);
    @(negedge clk);
    check("to_regrant",     32'(grant),    'h1);

    // Withdrawal while granted
    do_reset();
    async_req = 4'b0010;
    wait_grant("wd_grant", 10);
    check("wd_owner", 32'(grant), 'h2);
    async_req = 4'b0000;
    @(negedge clk);
    check("wd_hold1", 32'(grant), 'h2);
    @(negedge clk);
    check("wd_hold2", 32'(grant), 'h2);
    @(negedge clk);
    check("wd_drop",       32'(grant),   0);
    check("wd_no_timeout", 32'(timeout), 0);

    // Reset in the middle of a grant; pointer (now 2) must return to 0
    async_req = 4'b1111;
    wait_grant("mid_grant", 10);
    check("mid_owner", 32'(grant), 'h4);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_grant",   32'(grant),    0);
    check("mid_rst_busy",    32'(busy),     0);
    check("mid_rst_timeout", 32'(timeout),  0);
    check("mid_rst_sync",    32'(sync_req), 0);
    rst = 1'b0;
    wait_grant("post_mid_grant", 10);
    check("post_mid_owner", 32'(grant), 'h1);

    // Unknown request levels, with done toggling in every state
    do_reset();
    for (int c = 0; c < 100; c++) begin
      async_req = 4'bxxxx;
      done = (c % 5 == 2);
      @(negedge clk);
      check("meta_sync_known",    32'($isunknown(sync_req)), 0);
      check("meta_grant_known",   32'($isunknown(grant)),    0);
      check("meta_grant_onehot0", 32'($onehot0(grant)),      1);
    end
    async_req = 4'b0000;
    done = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
